// File: rtl/ad_ip_jesd204_tpl_adc_pack_pkg.sv
// Shared types and helpers for the TPL ADC sample packer.
// Mask helpers work on a 16-bit mask; callers zero-extend their enable.
package ad_ip_jesd204_tpl_adc_pack_pkg;

    localparam int MAX_CH = 16;
    localparam int CNT_W  = 5;

    localparam int DEF_W     = 16;
    localparam int DEF_D     = 2;
    localparam int DEF_CH    = 4;
    localparam int DEF_TOTAL = DEF_CH * DEF_D * DEF_W;

    typedef logic [MAX_CH-1:0] mask_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic cnt_t popcount(input mask_t m);
        cnt_t n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++)
            n = n + cnt_t'(m[i]);
        return n;
    endfunction

    function automatic logic is_pow2(input cnt_t n);
        return (n != '0) && ((n & (n - cnt_t'(1))) == '0);
    endfunction

    // Number of enabled channels strictly below channel c.
    function automatic cnt_t rank(input mask_t m, input int c);
        cnt_t r;
        r = '0;
        for (int i = 0; i < MAX_CH; i++)
            if (m[i] && (i < c))
                r = r + cnt_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pack_compact.sv
// Stage 1: squeeze the enabled channels of one beat into the low
// positions, sample-major (all enabled channels of d=0, then d=1, ...).
module ad_ip_jesd204_tpl_adc_pack_compact
    import ad_ip_jesd204_tpl_adc_pack_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DATA_PATH_WIDTH = 2
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic [NUM_CHANNELS-1:0]                           enable,
    input  logic                                              in_valid,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] adc_data,
    output logic                                              out_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] out_data
);

    localparam int W  = BITS_PER_SAMPLE;
    localparam int D  = DATA_PATH_WIDTH;
    localparam int TW = NUM_CHANNELS * D * W;

    logic [TW-1:0] comp;
    cnt_t          e_cnt;

    assign e_cnt = popcount(mask_t'(enable));

    // Route each enabled sample to position d*E + rank(c).
    always_comb begin
        comp = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int d = 0; d < D; d++)
                if (enable[c])
                    comp[(d * int'(e_cnt) + int'(rank(mask_t'(enable), c))) * W +: W] =
                        adc_data[(c * D + d) * W +: W];
    end

    // Register the compacted beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= comp;
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Packs enabled-channel samples into dense DMA words; stage 2 fills
// N = NUM_CHANNELS/E slots per word and strobes the finished word.
module ad_ip_jesd204_tpl_adc_pack
    import ad_ip_jesd204_tpl_adc_pack_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DATA_PATH_WIDTH = 2
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic [NUM_CHANNELS-1:0]                           enable,
    input  logic [NUM_CHANNELS-1:0]                           adc_valid,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] adc_data,
    output logic                                              fifo_wr_en,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] fifo_wr_data,
    output logic                                              fifo_wr_sync,
    input  logic                                              fifo_wr_overflow,
    output logic                                              adc_dovf,
    output logic                                              cfg_error
);

    localparam int W  = BITS_PER_SAMPLE;
    localparam int D  = DATA_PATH_WIDTH;
    localparam int NS = NUM_CHANNELS * D;
    localparam int TW = NS * W;
    localparam int KW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] enable_q;
    logic                    en_change;
    logic                    accept;
    cnt_t                    e_now;
    cnt_t                    e_q;

    logic                    s1_valid;
    logic [TW-1:0]           s1_data;

    logic [KW-1:0]           k;
    logic [TW-1:0]           acc;
    logic [TW-1:0]           acc_nx;
    int                      ed;
    int                      base;
    logic                    last;

    assign e_now     = popcount(mask_t'(enable));
    assign e_q       = popcount(mask_t'(enable_q));
    assign en_change = (enable != enable_q);
    assign accept    = (|(adc_valid & enable)) && !cfg_error && !en_change;

    ad_ip_jesd204_tpl_adc_pack_compact #(
        .NUM_CHANNELS    (NUM_CHANNELS),
        .BITS_PER_SAMPLE (BITS_PER_SAMPLE),
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
    ) u_compact (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .in_valid  (accept),
        .adc_data  (adc_data),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    assign ed   = int'(e_q) * D;
    assign base = int'(k) * ed;
    assign last = ((int'(k) + 1) * int'(e_q)) == NUM_CHANNELS;

    // Merge the stage-1 beat into slot k of the word being built.
    always_comb begin
        acc_nx = acc;
        for (int j = 0; j < NS; j++)
            if ((j >= base) && (j < base + ed))
                acc_nx[j * W +: W] = s1_data[(j - base) * W +: W];
    end

    // Mask tracking and configuration check.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q  <= '0;
            cfg_error <= 1'b0;
        end else begin
            enable_q  <= enable;
            cfg_error <= !is_pow2(e_now);
        end
    end

    // Slot counter, accumulator and word strobe; a mask change or a bad
    // mask throws away the partial word and any beat still in stage 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k            <= '0;
            acc          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (en_change || cfg_error) begin
                k   <= '0;
                acc <= '0;
            end else if (s1_valid) begin
                acc <= acc_nx;
                if (last) begin
                    k            <= '0;
                    fifo_wr_en   <= 1'b1;
                    fifo_wr_data <= acc_nx;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

    // Sync is armed by reset or a mask change and drops after one write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            fifo_wr_sync <= 1'b1;
        else if (en_change)
            fifo_wr_sync <= 1'b1;
        else if (fifo_wr_en)
            fifo_wr_sync <= 1'b0;
    end

    // Overflow is passed on one cycle later, not held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            adc_dovf <= 1'b0;
        else
            adc_dovf <= fifo_wr_overflow;
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Bench for the TPL ADC packer: directed cases with literal words plus a
// randomized run checked every cycle against a sample-queue model.
module tb_ad_ip_jesd204_tpl_adc_pack;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam int D  = 2;
    localparam int NS = NC * D;
    localparam int TW = NS * W;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NC-1:0] enable = '0;
    logic [NC-1:0] adc_valid = '0;
    logic [TW-1:0] adc_data = '0;
    logic          fifo_wr_overflow = 1'b0;
    logic          fifo_wr_en;
    logic [TW-1:0] fifo_wr_data;
    logic          fifo_wr_sync;
    logic          adc_dovf;
    logic          cfg_error;

    ad_ip_jesd204_tpl_adc_pack #(
        .NUM_CHANNELS    (NC),
        .BITS_PER_SAMPLE (W),
        .DATA_PATH_WIDTH (D)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .adc_valid        (adc_valid),
        .adc_data         (adc_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_sync     (fifo_wr_sync),
        .fifo_wr_overflow (fifo_wr_overflow),
        .adc_dovf         (adc_dovf),
        .cfg_error        (cfg_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [TW-1:0] act,
                         input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit good(input logic [NC-1:0] m);
        int n;
        n = $countones(m);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0]  mq[$];
    logic [W-1:0]  pend_s[$];
    bit            pend = 0;
    int            wr_cnt = 0;
    logic [NC-1:0] prev_en = '0;
    bit            exp_en = 0;
    logic [TW-1:0] exp_data = '0;
    bit            exp_sync = 1;
    bit            exp_dovf = 0;
    bit            exp_cfg = 0;

    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            pend_s.delete();
            pend     = 0;
            wr_cnt   = 0;
            prev_en  = '0;
            exp_en   = 0;
            exp_sync = 1;
            exp_dovf = 0;
            exp_cfg  = 0;
        end else begin
            bit change;
            bit nx_en;
            change = (enable != prev_en);
            nx_en  = 0;
            if (change) begin
                mq.delete();
                pend = 0;
            end else if (pend) begin
                foreach (pend_s[i]) mq.push_back(pend_s[i]);
                if (mq.size() == NS) begin
                    nx_en = 1;
                    for (int i = 0; i < NS; i++)
                        exp_data[i * W +: W] = mq[i];
                    mq.delete();
                end
            end
            if (exp_en) wr_cnt++;
            if (change) wr_cnt = 0;
            exp_sync = (wr_cnt == 0);
            pend = (|(adc_valid & enable)) && !change && good(enable);
            pend_s.delete();
            if (pend)
                for (int d = 0; d < D; d++)
                    for (int c = 0; c < NC; c++)
                        if (enable[c])
                            pend_s.push_back(adc_data[(c * D + d) * W +: W]);
            exp_en   = nx_en;
            exp_dovf = fifo_wr_overflow;
            exp_cfg  = !good(enable);
            prev_en  = enable;
        end
    end

    // ---------------- compare process + write capture ----------------
    logic [TW-1:0] wd[$];
    bit            ws[$];
    int            wc[$];

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            check("rst_wr_en", TW'(fifo_wr_en), '0);
            check("rst_wr_data", fifo_wr_data, '0);
            check("rst_sync", TW'(fifo_wr_sync), TW'(1));
            check("rst_dovf", TW'(adc_dovf), '0);
            check("rst_cfg", TW'(cfg_error), '0);
        end else begin
            check("wr_en", TW'(fifo_wr_en), TW'(exp_en));
            if (exp_en && fifo_wr_en) begin
                check("wr_data", fifo_wr_data, exp_data);
                check("wr_sync", TW'(fifo_wr_sync), TW'(exp_sync));
            end
            check("dovf", TW'(adc_dovf), TW'(exp_dovf));
            check("cfg_error", TW'(cfg_error), TW'(exp_cfg));
            if (fifo_wr_en) begin
                wd.push_back(fifo_wr_data);
                ws.push_back(fifo_wr_sync);
                wc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_wq();
        wd.delete();
        ws.delete();
        wc.delete();
    endtask

    task automatic set_en(input logic [NC-1:0] m);
        enable = m;
        tick(2);
    endtask

    task automatic beat(input logic [TW-1:0] dat, output int bc);
        adc_valid = '1;
        adc_data  = dat;
        bc        = cyc;
        tick();
        adc_valid = '0;
        adc_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_wr(input string nm, input int idx,
                            input logic [TW-1:0] d, input bit s);
        if (idx < wd.size()) begin
            check({nm, "_data"}, wd[idx], d);
            check({nm, "_sync"}, TW'(ws[idx]), TW'(s));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: write %0d missing, got %0d writes",
                     nm, idx, wd.size());
        end
    endtask

    function automatic int wcyc(input int idx);
        return (idx < wc.size()) ? wc[idx] : -1;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [TW-1:0] dat;
        logic [TW-1:0] dat2;
        logic [NC-1:0] pick;
        int bc;
        int bc2;

        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);

        // all channels: identity layout, back-to-back writes
        set_en(4'b1111);
        clear_wq();
        for (int i = 0; i < NS; i++) dat[i * W +: W] = W'(i);
        dat2 = ~dat;
        beat(dat, bc);
        beat(dat2, bc2);
        tick(4);
        check("t1_count", TW'(wd.size()), TW'(2));
        check_wr("t1_w0", 0,
            128'h0007_0005_0003_0001_0006_0004_0002_0000, 1'b1);
        check_wr("t1_w1", 1,
            128'hfff8_fffa_fffc_fffe_fff9_fffb_fffd_ffff, 1'b0);
        check("t1_lat", TW'(wcyc(0)), TW'(bc + 2));
        check("t1_b2b", TW'(wcyc(1)), TW'(bc2 + 2));

        // two channels (0 and 2): two beats per word, A in lower half
        set_en(4'b0101);
        clear_wq();
        beat(128'h5555_5555_0c01_0c00_4444_4444_0a01_0a00, bc);
        beat(128'h6666_6666_0d01_0d00_7777_7777_0b01_0b00, bc);
        tick(4);
        check("t2_count", TW'(wd.size()), TW'(1));
        check_wr("t2_w0", 0,
            128'h0d01_0b01_0d00_0b00_0c01_0a01_0c00_0a00, 1'b1);

        // one channel with an idle gap: arrival order, t+2 latency
        set_en(4'b0001);
        clear_wq();
        beat({96'h0, 16'h3001, 16'h3000}, bc);
        beat({96'h0, 16'h3003, 16'h3002}, bc);
        tick(3);
        beat({96'h0, 16'h3005, 16'h3004}, bc);
        beat({96'h0, 16'h3007, 16'h3006}, bc);
        tick(4);
        check("t3_count", TW'(wd.size()), TW'(1));
        check_wr("t3_w0", 0,
            128'h3007_3006_3005_3004_3003_3002_3001_3000, 1'b1);
        check("t3_lat", TW'(wcyc(0)), TW'(bc + 2));

        // three channels is illegal: no writes, then recover on two
        enable = 4'b0111;
        tick();
        check("t4_cfg_set", TW'(cfg_error), TW'(1));
        clear_wq();
        for (int i = 0; i < 20; i++) beat({$urandom, $urandom, $urandom, $urandom}, bc);
        tick(3);
        check("t4_no_wr", TW'(wd.size()), '0);
        set_en(4'b0011);
        check("t4_cfg_clr", TW'(cfg_error), '0);
        beat({$urandom, $urandom, $urandom, $urandom}, bc);
        beat({$urandom, $urandom, $urandom, $urandom}, bc);
        tick(4);
        check("t4_count", TW'(wd.size()), TW'(1));
        check("t4_sync", TW'((ws.size() > 0) ? ws[0] : 1'b0), TW'(1));

        // enable change mid-word discards the partial word
        set_en(4'b0001);
        clear_wq();
        beat({96'h0, 16'hdead, 16'hdead}, bc);
        beat({96'h0, 16'hbeef, 16'hbeef}, bc);
        set_en(4'b0011);
        beat(128'h0_0000_0000_0000_0000_1103_1102_1101_1100, bc);
        beat(128'h0_0000_0000_0000_0000_2203_2202_2201_2200, bc);
        tick(4);
        check("t5_count", TW'(wd.size()), TW'(1));
        check_wr("t5_w0", 0,
            128'h2203_2201_2202_2200_1103_1101_1102_1100, 1'b1);

        // overflow is echoed for exactly one cycle
        fifo_wr_overflow = 1'b1;
        tick();
        fifo_wr_overflow = 1'b0;
        check("t6_dovf_hi", TW'(adc_dovf), TW'(1));
        tick();
        check("t6_dovf_lo", TW'(adc_dovf), '0);

        // asynchronous reset in the middle of a word
        set_en(4'b0001);
        for (int i = 0; i < 4; i++) beat({96'h0, 16'h4444, 16'h4444}, bc);
        tick(3);
        clear_wq();
        beat({$urandom, $urandom, $urandom, $urandom}, bc);
        beat({$urandom, $urandom, $urandom, $urandom}, bc);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("t7_wr_en", TW'(fifo_wr_en), '0);
        check("t7_data", fifo_wr_data, '0);
        check("t7_sync", TW'(fifo_wr_sync), TW'(1));
        check("t7_dovf", TW'(adc_dovf), '0);
        check("t7_cfg", TW'(cfg_error), '0);
        tick(3);
        resetn = 1'b1;
        tick(6);
        check("t7_no_wr", TW'(wd.size()), '0);
        for (int i = 0; i < 4; i++) beat({$urandom, $urandom, $urandom, $urandom}, bc);
        tick(4);
        check("t7_count", TW'(wd.size()), TW'(1));
        check("t7_sync_after", TW'((ws.size() > 0) ? ws[0] : 1'b0), TW'(1));

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pick = NC'($urandom);
                if ($urandom_range(0, 3) != 0)
                    repeat (16) if (!good(pick)) pick = NC'($urandom);
                enable = pick;
            end
            adc_valid = ($urandom_range(0, 3) != 0) ? NC'($urandom) : '0;
            adc_data  = {$urandom, $urandom, $urandom, $urandom};
            fifo_wr_overflow = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) begin
                resetn = 1'b0;
                tick(2);
                resetn = 1'b1;
            end
            tick();
        end
        adc_valid = '0;
        fifo_wr_overflow = 1'b0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
